// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed six-digit 7-segment driver for the watch display. One digit
// slot is lit at a time, SCAN_DIV clocks per slot, left to right (d1..d6).
// The digit codes and blink mask are captured once per scan frame, at the last
// cycle of the d6 slot, so a frame is always drawn from one consistent set of
// values. The first cycle of every slot keeps all anodes off (anti-ghosting).
//
// Parameters
//   SCAN_DIV    clk cycles per digit slot (>= 2)
//   BLINK_HALF  clk cycles per blink half-period (visible / hidden)
//
// Ports
//   clk     in   1  system clock, rising edge
//   reset   in   1  synchronous, active-high reset
//   d1..d6  in   4  digit codes, d1 = leftmost
//   flash   in   3  blink mask: [2]=d1,d2  [1]=d3,d4  [0]=d5,d6
//   an      out  6  active-low anode enables, an[5]=d1 ... an[0]=d6
//   seg     out  7  active-low segments {g,f,e,d,c,b,a}
//   dp      out  1  active-low decimal point (hour/minute separators)
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [3:0] d6,
    input  logic [2:0] flash,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } phase_t;

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [BW-1:0] bcnt;
    phase_t        phase;
    logic [3:0]    sd [0:5];
    logic [2:0]    sflash;

    logic          pcnt_last;
    logic          bcnt_last;
    logic          snap;
    logic          restart;
    logic [3:0]    cur_code;
    logic          cur_flash;
    logic          hidden;
    logic [5:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    // Active-low gfedcba patterns. Codes 10/11/12 give the AM/PM letters and
    // the dash used when the alarm is off; 13..15 are blank.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pattern;
        pattern = 7'h7F;
        case (code)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            4'd10:   pattern = 7'h08;
            4'd11:   pattern = 7'h0C;
            4'd12:   pattern = 7'h3F;
            default: pattern = 7'h7F;
        endcase
        return pattern;
    endfunction

    // Frame bookkeeping. The snapshot point is the final cycle of the d6 slot,
    // and a changed blink mask at that point restarts blinking in the visible
    // half so a newly flashing group never starts out dark.
    always_comb begin
        pcnt_last = (pcnt == PW'(SCAN_DIV - 1));
        bcnt_last = (bcnt == BW'(BLINK_HALF - 1));
        snap      = pcnt_last && (idx == 3'd5);
        restart   = snap && (flash != sflash);
    end

    // Select the snapshot digit and the flash group bit for the active slot.
    // Digits pair up into groups (d1,d2), (d3,d4), (d5,d6) from the MSB down.
    always_comb begin
        cur_code  = 4'd15;
        cur_flash = 1'b0;
        case (idx)
            3'd0: begin cur_code = sd[0]; cur_flash = sflash[2]; end
            3'd1: begin cur_code = sd[1]; cur_flash = sflash[2]; end
            3'd2: begin cur_code = sd[2]; cur_flash = sflash[1]; end
            3'd3: begin cur_code = sd[3]; cur_flash = sflash[1]; end
            3'd4: begin cur_code = sd[4]; cur_flash = sflash[0]; end
            3'd5: begin cur_code = sd[5]; cur_flash = sflash[0]; end
            default: begin cur_code = 4'd15; cur_flash = 1'b0; end
        endcase
        hidden = (phase == PH_HIDDEN) && cur_flash;
    end

    // Next output values. Slot cycle 0 is the dead time between digits: all
    // anodes and segments off. The separators sit after d2 and d4 and vanish
    // whenever that digit is dark, whether from a blank code or from blinking.
    always_comb begin
        an_next  = 6'h3F;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (pcnt != '0) begin
            an_next = ~(6'b100000 >> idx);
            if (!hidden) begin
                seg_next = decode(cur_code);
                if (((idx == 3'd1) || (idx == 3'd3)) && (cur_code <= 4'd12)) begin
                    dp_next = 1'b0;
                end
            end
        end
    end

    // Scan position: pcnt walks through a slot, idx steps through the six
    // digit positions and wraps back to d1 after d6.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= 3'd0;
        end else if (pcnt_last) begin
            pcnt <= '0;
            idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Frame snapshot. Inputs are only looked at on the snapshot cycle; reset
    // loads blank codes so the first frame after reset is dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                sd[i] <= 4'd15;
            end
            sflash <= 3'b000;
        end else if (snap) begin
            sd[0]  <= d1;
            sd[1]  <= d2;
            sd[2]  <= d3;
            sd[3]  <= d4;
            sd[4]  <= d5;
            sd[5]  <= d6;
            sflash <= flash;
        end
    end

    // Blink timer. A restart takes priority over a terminal count landing on
    // the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt  <= '0;
            phase <= PH_VISIBLE;
        end else if (restart) begin
            bcnt  <= '0;
            phase <= PH_VISIBLE;
        end else if (bcnt_last) begin
            bcnt  <= '0;
            phase <= (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    // Registered display outputs, one clock behind the scan state so the
    // pins never glitch on counter transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 6'h3F;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Drives the scan driver with the small-parameter scenarios (SCAN_DIV=4,
// BLINK_HALF=64) followed by a randomized run. A behavioural model derives
// the expected display from the elapsed cycle count since reset, the frame
// snapshots and the time since the last blink restart, and is compared to
// the DUT every clock. Literal expectations at chosen cycles pin the model.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int S  = 4;
    localparam int BH = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] d1 = 4'd0;
    logic [3:0] d2 = 4'd0;
    logic [3:0] d3 = 4'd0;
    logic [3:0] d4 = 4'd0;
    logic [3:0] d5 = 4'd0;
    logic [3:0] d6 = 4'd0;
    logic [2:0] flash = 3'b000;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int errors = 0;
    int checks = 0;
    int tbEdge = 0;

    seg7_scan_driver #(
        .SCAN_DIV  (S),
        .BLINK_HALF(BH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .d1   (d1),
        .d2   (d2),
        .d3   (d3),
        .d4   (d4),
        .d5   (d5),
        .d6   (d6),
        .flash(flash),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    // Compare all three outputs against an expectation.
    task automatic checkOutput(input string name, input logic [5:0] ea,
                               input logic [6:0] es, input logic ed);
        checks++;
        if (an !== ea || seg !== es || dp !== ed) begin
            errors++;
            $display("[TB] FAIL %s t=%0t: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                     name, $time, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic applyStimulus(input int a, input int b, input int c, input int d,
                                 input int e, input int f, input int fl);
        d1 = 4'(a); d2 = 4'(b); d3 = 4'(c);
        d4 = 4'(d); d5 = 4'(e); d6 = 4'(f);
        flash = 3'(fl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tbEdge++;
    endtask

    task automatic stepTo(input int e);
        while (tbEdge < e) tick();
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] segTab [16];
    int         n = 0;
    int         r = 0;
    int         msd [6];
    int         msf = 0;
    bit         modelOn = 1'b0;
    logic [5:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;

    initial begin
        segTab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h0C, 7'h3F, 7'h7F, 7'h7F, 7'h7F};
        for (int i = 0; i < 6; i++) msd[i] = 15;
    end

    // The state before edge number n (counted from reset release) is fully
    // determined by n: slot cycle n%S, digit (n/S)%6; blink phase from the
    // cycles elapsed since the last restart point r.
    always begin
        int  p;
        int  k;
        bit  hid;
        bit  dark;
        @(posedge clk);
        if (reset) begin
            eAn = 6'h3F; eSeg = 7'h7F; eDp = 1'b1;
            n = 0; r = 0; msf = 0;
            for (int i = 0; i < 6; i++) msd[i] = 15;
            modelOn = 1'b1;
        end else if (modelOn) begin
            p   = n % S;
            k   = (n / S) % 6;
            hid = (((n - r) / BH) % 2) == 1;
            dark = hid && (((msf >> (2 - k / 2)) & 1) == 1);
            if (p == 0) begin
                eAn = 6'h3F; eSeg = 7'h7F; eDp = 1'b1;
            end else begin
                eAn  = 6'h3F ^ (6'd1 << (5 - k));
                eSeg = dark ? 7'h7F : segTab[msd[k]];
                eDp  = !((k == 1 || k == 3) && !dark && msd[k] <= 12);
            end
            if (k == 5 && p == S - 1) begin
                if (int'(flash) != msf) r = n + 1;
                msd[0] = d1; msd[1] = d2; msd[2] = d3;
                msd[3] = d4; msd[4] = d5; msd[5] = d6;
                msf = flash;
            end
            n++;
        end
        #1;
        if (modelOn) checkOutput("model", eAn, eSeg, eDp);
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held three clocks.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("lit_reset", 6'h3F, 7'h7F, 1'b1);
        end
        reset = 1'b0;
        tbEdge = 0;

        // Scenario 2 digits; the first frame is still blank.
        applyStimulus(1, 2, 3, 4, 5, 9, 0);
        stepTo(2);  checkOutput("lit_first_blank", 6'h1F, 7'h7F, 1'b1);
        stepTo(26); checkOutput("lit_s2_d1", 6'h1F, 7'h79, 1'b1);
        stepTo(30); checkOutput("lit_s2_d2_dp", 6'h2F, 7'h24, 1'b0);
        stepTo(46); checkOutput("lit_s2_d6", 6'h3E, 7'h10, 1'b1);
        stepTo(49); checkOutput("lit_s2_ghost", 6'h3F, 7'h7F, 1'b1);

        // AM 12:30 with a blank d2.
        applyStimulus(10, 15, 1, 2, 3, 0, 0);
        stepTo(74); checkOutput("lit_s3_A", 6'h1F, 7'h08, 1'b1);
        stepTo(78); checkOutput("lit_s3_blank_d2", 6'h2F, 7'h7F, 1'b1);
        stepTo(86); checkOutput("lit_s3_d4_dp", 6'h3B, 7'h24, 1'b0);
        stepTo(94); checkOutput("lit_s3_d6", 6'h3E, 7'h40, 1'b1);

        // Flash the d1,d2 group.
        stepTo(96);
        applyStimulus(1, 2, 3, 4, 5, 9, 4);
        stepTo(122); checkOutput("lit_s4_visible", 6'h1F, 7'h79, 1'b1);
        stepTo(194); checkOutput("lit_s4_hidden_d1", 6'h1F, 7'h7F, 1'b1);
        stepTo(198); checkOutput("lit_s4_hidden_d2", 6'h2F, 7'h7F, 1'b1);
        stepTo(202); checkOutput("lit_s4_d3_steady", 6'h37, 7'h30, 1'b1);

        // Alarm-off dashes, then a mid-frame change that must wait a frame.
        stepTo(203);
        applyStimulus(12, 12, 12, 12, 12, 12, 0);
        stepTo(218); checkOutput("lit_s5_dash", 6'h1F, 7'h3F, 1'b1);
        stepTo(220);
        applyStimulus(8, 8, 8, 8, 8, 8, 0);
        stepTo(230); checkOutput("lit_s5_hold", 6'h3B, 7'h3F, 1'b0);
        stepTo(242); checkOutput("lit_s5_next", 6'h1F, 7'h00, 1'b1);

        // Reset in the middle of the d4 slot.
        stepTo(254);
        reset = 1'b1;
        tick();
        checkOutput("lit_s6_reset", 6'h3F, 7'h7F, 1'b1);
        reset = 1'b0;
        tbEdge = 0;
        stepTo(2);  checkOutput("lit_s6_blank", 6'h1F, 7'h7F, 1'b1);
        stepTo(26); checkOutput("lit_s6_resume", 6'h1F, 7'h00, 1'b1);

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)
                applyStimulus($urandom_range(0, 15), $urandom_range(0, 15),
                              $urandom_range(0, 15), $urandom_range(0, 15),
                              $urandom_range(0, 15), $urandom_range(0, 15), flash);
            if ($urandom_range(0, 299) == 0)
                flash = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
